// File: rtl/trig_pkg.sv
// trig_pkg: shared state encodings, op codes and float constants for trig_scheduler
package trig_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESPOND} state_t;
  localparam logic OP_SIN = 1'b0;
  localparam logic OP_COS = 1'b1;
  localparam logic [31:0] FLOAT_QNAN = 32'h7FC00000;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr+1, one-hot grant plus index
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/trig_scheduler.sv
// trig_scheduler: round-robin sharing of one trig datapath; define WATCHDOG_EN to abort hung jobs
module trig_scheduler
  import trig_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TIMEOUT = 64,
  localparam int IW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [32*NREQ-1:0] req_angle,
  input  logic [NREQ-1:0]   req_op,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IW-1:0]     rsp_id,
  output logic              rsp_op,
  output logic [31:0]       rsp_data,
  output logic              rsp_timeout,
  input  logic              pipe_ready,
  output logic              pipe_start,
  output logic [31:0]       pipe_angle,
  output logic              pipe_op,
  input  logic              pipe_done,
  input  logic [31:0]       pipe_result,
  output logic              pipe_abort
);
`ifdef WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, id_q, id_d, gidx;
  logic [NREQ-1:0] gnt_q, gnt_d, gnt;
  logic [31:0] angle_q, angle_d, data_q, data_d;
  logic op_q, op_d, tmo_q, tmo_d, done_q, any, ev, wd_fire;
  logic [7:0] cnt_q, cnt_d;
  rr_arbiter #(.N(NREQ)) u_arb (.req(req_valid), .ptr(ptr_q), .gnt(gnt), .idx(gidx), .any(any));
  assign ev = pipe_done & ~done_q;
  assign wd_fire = WD && state_q == S_WAIT && cnt_q == 8'(TIMEOUT) && !ev;
  assign req_ready = state_q == S_LAUNCH ? gnt_q : '0;
  assign pipe_start = state_q == S_LAUNCH;
  assign pipe_angle = angle_q;
  assign pipe_op = op_q;
  assign pipe_abort = wd_fire;
  assign rsp_valid = state_q == S_RESPOND;
  assign rsp_id = id_q;
  assign rsp_op = op_q;
  assign rsp_data = data_q;
  assign rsp_timeout = tmo_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    gnt_d = gnt_q;
    angle_d = angle_q;
    op_d = op_q;
    data_d = data_q;
    tmo_d = tmo_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: if (any && pipe_ready) begin
        state_d = S_LAUNCH;
        ptr_d = gidx;
        id_d = gidx;
        gnt_d = gnt;
        angle_d = req_angle[32*gidx +: 32];
        op_d = req_op[gidx];
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        cnt_d = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (ev || wd_fire) begin
          state_d = S_RESPOND;
          data_d = ev ? pipe_result : FLOAT_QNAN;
          tmo_d = !ev;
        end
      end
      default: if (rsp_ready) state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q <= IW'(NREQ - 1);
      id_q <= '0;
      gnt_q <= '0;
      angle_q <= '0;
      op_q <= 1'b0;
      data_q <= '0;
      tmo_q <= 1'b0;
      cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      gnt_q <= gnt_d;
      angle_q <= angle_d;
      op_q <= op_d;
      data_q <= data_d;
      tmo_q <= tmo_d;
      cnt_q <= cnt_d;
      done_q <= pipe_done;
    end
  end
endmodule

// File: tb/tb_trig_scheduler.sv
// tb_trig_scheduler: directed checks of arbitration, handshakes, sticky done and reset
module tb_trig_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req_valid = '0, req_op = '0, req_ready;
  logic [127:0] req_angle;
  logic rsp_valid, rsp_ready = 1'b0, rsp_op, rsp_timeout;
  logic [1:0] rsp_id;
  logic [31:0] rsp_data, pipe_angle, pipe_result = '0;
  logic pipe_ready = 1'b1, pipe_start, pipe_op, pipe_done = 1'b0, pipe_abort;
  logic [31:0] ang [4] = '{32'h41F00000, 32'h42340000, 32'h42700000, 32'h42B40000};
  int n_vec = 0, n_err = 0;
  assign req_angle = {ang[3], ang[2], ang[1], ang[0]};
  always #5 clk = ~clk;
  trig_scheduler #(.NREQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_angle(req_angle), .req_op(req_op),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_op(rsp_op), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .pipe_ready(pipe_ready),
    .pipe_start(pipe_start), .pipe_angle(pipe_angle), .pipe_op(pipe_op), .pipe_done(pipe_done),
    .pipe_result(pipe_result), .pipe_abort(pipe_abort));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask
  task automatic wait_launch;
    int i;
    for (i = 0; i < 10 && !pipe_start; i++) tick;
    chk("launch_seen", pipe_start, 1);
  endtask
  task automatic finish_job(input int id, input logic [31:0] res);
    chk("req_ready_gnt", req_ready, 64'(4'b1 << id));
    chk("pipe_angle", pipe_angle, ang[id]);
    chk("pipe_op", pipe_op, req_op[id]);
    tick;
    chk("req_ready_1cyc", req_ready, 0);
    chk("pipe_start_1cyc", pipe_start, 0);
    pipe_done = 1'b1;
    pipe_result = res;
    tick;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, id);
    chk("rsp_data", rsp_data, res);
    chk("rsp_timeout", rsp_timeout, 0);
    pipe_done = 1'b0;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
  endtask
  initial begin
    do_reset;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_pipe_start", pipe_start, 0);
    chk("rst_pipe_angle", pipe_angle, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_pipe_abort", pipe_abort, 0);
    req_valid = 4'b0001;
    tick;
    chk("k1_pipe_start", pipe_start, 1);
    req_valid = 4'b0000;
    finish_job(0, 32'h3F000000);
    do_reset;
    req_valid = 4'b1111;
    req_op = 4'b1010;
    for (int n = 0; n < 5; n++) begin
      wait_launch;
      finish_job(n % 4, 32'h3F000000 + 32'(n));
    end
    req_valid = '0;
    req_op = '0;
    do_reset;
    pipe_ready = 1'b0;
    req_valid = 4'b0010;
    for (int n = 0; n < 3; n++) begin
      tick;
      chk("no_start_busy", pipe_start, 0);
    end
    pipe_ready = 1'b1;
    tick;
    chk("start_after_ready", pipe_start, 1);
    req_valid = '0;
    finish_job(1, 32'h3F5DB3D7);
    pipe_done = 1'b1;
    tick;
    req_valid = 4'b0100;
    tick;
    chk("stale_launch", pipe_start, 1);
    req_valid = '0;
    for (int n = 0; n < 4; n++) begin
      tick;
      chk("stale_ignored", rsp_valid, 0);
    end
    pipe_done = 1'b0;
    tick;
    chk("stale_low", rsp_valid, 0);
    pipe_done = 1'b1;
    pipe_result = 32'h3F800000;
    tick;
    chk("stale_rsp_valid", rsp_valid, 1);
    chk("stale_rsp_data", rsp_data, 32'h3F800000);
    chk("stale_rsp_id", rsp_id, 2);
    pipe_done = 1'b0;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    wait_launch;
    tick;
    pipe_done = 1'b1;
    pipe_result = 32'hBF000000;
    tick;
    pipe_done = 1'b0;
    for (int n = 0; n < 10; n++) begin
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, 32'hBF000000);
      chk("stall_no_launch", pipe_start, 0);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("release_idle", {rsp_valid, pipe_start}, 0);
    tick;
    chk("release_launch", pipe_start, 1);
    chk("release_gnt", req_ready, 4'b1000);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_outs", {req_ready, rsp_valid, pipe_start, pipe_abort, rsp_timeout}, 0);
    chk("midrst_angle", pipe_angle, 0);
    chk("midrst_data", rsp_data, 0);
    req_valid = '0;
`ifdef WATCHDOG_EN
    do_reset;
    req_valid = 4'b0001;
    wait_launch;
    req_valid = '0;
    begin
      int n;
      for (n = 0; n < 60 && !pipe_abort; n++) tick;
      chk("wd_abort", pipe_abort, 1);
      tick;
      chk("wd_abort_1cyc", pipe_abort, 0);
      chk("wd_rsp_valid", rsp_valid, 1);
      chk("wd_rsp_data", rsp_data, 32'h7FC00000);
      chk("wd_rsp_timeout", rsp_timeout, 1);
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
